wb_release_arbiter: RTL and testbench
=====================================

// Module: wb_release_arbiter
// PURPOSE
// - Writeback end of the data-hazard scoreboard protocol. The scoreboard reserves rd at issue;
//   this block retires results and releases the reservation.
// - Accepts results from three execute sources: ALU (addi/add), LSU (loads) and JMP (jal/jalr/lui/auipc).
// - Buffers each source in its own small FIFO and arbitrates them round-robin onto the single
//   register-file write port.
// - Emits a release strobe per retired rd so the scoreboard clears that rd's pending/busy bits.
// PARAMETERS
// XLEN   32  data width of a writeback result
// DEPTH  2   entries per source FIFO (power of two, >=2)
// PORTS
// clk          in   1     clock, all state updates on rising edge
// rst          in   1     synchronous active-high reset
// alu_valid    in   1     ALU result offered
// alu_rd       in   5     ALU destination register
// alu_data     in   XLEN  ALU result
// alu_ready    out  1     ALU FIFO can accept
// lsu_valid    in   1     load result offered
// lsu_rd       in   5     load destination register
// lsu_data     in   XLEN  load result
// lsu_ready    out  1     LSU FIFO can accept
// jmp_valid    in   1     jump/upper-immediate result offered
// jmp_rd       in   5     jump/upper-immediate destination register
// jmp_data     in   XLEN  jump/upper-immediate result
// jmp_ready    out  1     JMP FIFO can accept
// flush        in   1     branch-taken kill: drop all buffered results
// rf_we        out  1     register-file write enable (registered)
// rf_waddr     out  5     register-file write address (registered)
// rf_wdata     out  XLEN  register-file write data (registered)
// rel_valid    out  1     release strobe to scoreboard; equals rf_we
// rel_rd       out  5     released register; equals rf_waddr
// release_all  out  1     1-cycle pulse: scoreboard clears every pending bit
// pend         out  32    bit r set while any FIFO holds a valid entry for rd==r; bit 0 always 0
// BEHAVIOUR
// - Reset: all FIFOs empty. rf_we=0, rf_waddr=0, rf_wdata=0, rel_valid=0, rel_rd=0, release_all=0, pend=0.
//   Round-robin pointer = JMP, so ALU has first priority.
// - Handshake: a transfer happens at a rising edge with x_valid & x_ready.
//   x_ready = !full_x & !flush. It depends only on FIFO count and flush, never on x_valid or pop.
//   A full FIFO therefore refuses the push even if it pops in the same cycle.
// - rd==0: the handshake completes and the result is discarded. No entry, no write, no release.
// - Arbitration: each cycle pick the first non-empty FIFO in cyclic order after the last granted source
//   (order ALU->LSU->JMP->ALU). Pop it and update the pointer to it.
//   On the next edge: rf_we=1, rf_waddr/rf_wdata=entry, rel_valid=1, rel_rd=entry rd.
//   If no FIFO is non-empty, rf_we=0 and rel_valid=0; waddr/wdata hold their previous value.
// - Latency: a result accepted at edge N appears on rf_we at edge N+1 at the earliest.
//   Throughput is 1 write/cycle across all sources.
// - Ordering: FIFO order is kept within a source. No ordering across sources; the scoreboard forbids
//   WAW across sources. If the same rd sits in two FIFOs, each entry is written and released separately.
// - pend: combinational OR over valid entries, decoded one-hot from rd.
//   It updates the cycle after push or pop.
// - Flush (sync, highest priority after rst):
//   - at the flush edge all FIFOs empty, no pop is granted, and same-cycle inputs are not accepted;
//   - next cycle rf_we=0, rel_valid=0, release_all=1 for exactly one cycle;
//   - the pointer is unchanged;
//   - flush held N cycles gives release_all high N cycles.
// - Simultaneous push and pop on one FIFO (not full): count unchanged, both take effect.
// - Reset mid-operation overrides flush and all traffic; buffered results are lost.
// - Counters: FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   Counts are log2(DEPTH)+1 bits, saturating is impossible by construction.
// TESTING
// T1 ALU push rd=5 data=0xA5 at edge 1 -> edge 2: rf_we=1 waddr=5 wdata=0xA5 rel_rd=5;
//    pend[5]=1 only during cycle 1-2.
// T2 ALU/LSU/JMP push rd=1/2/3 same edge -> writes on 3 consecutive cycles, order 1,2,3;
//    repeat with rd=4/5/6 -> order rotates by pointer (4,5,6 since JMP was last).
// T3 hold lsu_valid with no grants possible (DEPTH=2, other sources streaming) -> lsu_ready drops after
//    2 accepts; no data lost; 3rd accepted only after a pop.
// T4 push rd=0 on ALU -> alu_ready=1, no rf_we, no rel_valid, pend=0.
// T5 fill all FIFOs, assert flush 1 cycle with jmp_valid=1 -> jmp_ready=0; next cycle rf_we=0,
//    release_all=1; pend=0; no writes afterwards.
// T6 assert rst while FIFOs hold entries and flush=1 -> next cycle all outputs 0;
//    first later ALU push is granted before LSU/JMP pushed on the same edge.

Source files
------------

// File: rtl/wb_release_arbiter.sv
// wb_release_arbiter
// Writeback end of the data-hazard scoreboard. Results from three execute
// sources (ALU, LSU, JMP) are each buffered in a small FIFO and arbitrated
// round-robin onto the single register-file write port. Every retired rd is
// echoed as a release strobe so the scoreboard can clear its pending bit.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/rd/data/ready  ALU result channel (ready = FIFO can accept)
//   lsu_valid/rd/data/ready  load result channel
//   jmp_valid/rd/data/ready  jal/jalr/lui/auipc result channel
//   flush                    branch-taken kill, drops every buffered result
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   rel_valid/rel_rd         release strobe (mirrors rf_we / rf_waddr)
//   release_all              one pulse per flush cycle, clears all pending bits
//   pend                     one-hot OR of rd over all buffered entries
module wb_release_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            jmp_valid,
  input  logic [4:0]      jmp_rd,
  input  logic [XLEN-1:0] jmp_data,
  output logic            jmp_ready,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rel_valid,
  output logic [4:0]      rel_rd,
  output logic            release_all,
  output logic [31:0]     pend
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned NSRC = 3;

  // Source index doubles as the round-robin "last granted" state.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_JMP = 2'd2
  } src_e;

  src_e rr_q, rr_d, sel;

  logic [NSRC-1:0] in_valid;
  logic [4:0]      in_rd   [NSRC];
  logic [XLEN-1:0] in_data [NSRC];

  logic [NSRC-1:0] src_ready;
  logic [NSRC-1:0] src_push;
  logic [NSRC-1:0] src_pop;
  logic [NSRC-1:0] src_empty;
  logic [4:0]      head_rd   [NSRC];
  logic [XLEN-1:0] head_data [NSRC];
  logic [31:0]     src_pend  [NSRC];

  logic            pop_any;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            release_all_q;

  assign in_valid   = {jmp_valid, lsu_valid, alu_valid};
  assign in_rd[0]   = alu_rd;
  assign in_rd[1]   = lsu_rd;
  assign in_rd[2]   = jmp_rd;
  assign in_data[0] = alu_data;
  assign in_data[1] = lsu_data;
  assign in_data[2] = jmp_data;

  assign alu_ready = src_ready[0];
  assign lsu_ready = src_ready[1];
  assign jmp_ready = src_ready[2];

  // ---------------------------------------------------------------------
  // Per-source FIFOs
  // ---------------------------------------------------------------------
  for (genvar s = 0; s < NSRC; s++) begin : g_fifo
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            full;
    logic [DEPTH-1:0] live;
    logic [31:0]     pend_v;

    assign full         = (cnt_q == CW'(DEPTH));
    assign src_empty[s] = (cnt_q == '0);
    // Ready looks only at occupancy and flush, so a full FIFO refuses a
    // push even when it is being popped in the same cycle.
    assign src_ready[s] = ~full & ~flush;
    // rd==0 completes the handshake but is never buffered.
    assign src_push[s]  = in_valid[s] & src_ready[s] & (in_rd[s] != 5'd0);
    assign head_rd[s]   = rd_q[rptr_q];
    assign head_data[s] = data_q[rptr_q];

    always_comb begin
      cnt_d = cnt_q;
      unique case ({src_push[s], src_pop[s]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (src_push[s]) begin
          rd_q[wptr_q]   <= in_rd[s];
          data_q[wptr_q] <= in_data[s];
          wptr_q         <= wptr_q + AW'(1);
        end
        if (src_pop[s]) begin
          rptr_q <= rptr_q + AW'(1);
        end
        cnt_q <= cnt_d;
      end
    end

    // A slot holds a live entry when its distance from the read pointer
    // (modulo DEPTH) is below the current count.
    for (genvar k = 0; k < DEPTH; k++) begin : g_live
      logic [AW-1:0] offset;
      assign offset  = AW'(k) - rptr_q;
      assign live[k] = ({1'b0, offset} < cnt_q);
    end

    for (genvar b = 0; b < 32; b++) begin : g_bit
      logic [DEPTH-1:0] hit;
      for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign hit[k] = live[k] & (rd_q[k] == 5'(b));
      end
      assign pend_v[b] = |hit;
    end

    assign src_pend[s] = pend_v;
  end

  assign pend = (src_pend[0] | src_pend[1] | src_pend[2]) & ~32'd1;

  // ---------------------------------------------------------------------
  // Round-robin arbiter: search starts just after the last granted source
  // ---------------------------------------------------------------------
  always_comb begin
    rr_d    = rr_q;
    sel     = rr_q;
    src_pop = '0;
    pop_any = 1'b0;
    if (!flush) begin
      unique case (rr_q)
        SRC_ALU: sel = !src_empty[1] ? SRC_LSU : (!src_empty[2] ? SRC_JMP : SRC_ALU);
        SRC_LSU: sel = !src_empty[2] ? SRC_JMP : (!src_empty[0] ? SRC_ALU : SRC_LSU);
        default: sel = !src_empty[0] ? SRC_ALU : (!src_empty[1] ? SRC_LSU : SRC_JMP);
      endcase
      // The fallback of each chain is rr_q itself, which is only chosen
      // when it is the sole non-empty source.
      pop_any = ~&src_empty;
      if (pop_any) begin
        rr_d         = sel;
        src_pop[sel] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered write port, release strobe and release_all pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q          <= SRC_JMP;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      release_all_q <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      rf_we_q       <= pop_any;
      release_all_q <= flush;
      if (pop_any) begin
        rf_waddr_q <= head_rd[sel];
        rf_wdata_q <= head_data[sel];
      end
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rel_valid   = rf_we_q;
  assign rel_rd      = rf_waddr_q;
  assign release_all = release_all_q;

endmodule

// File: tb/tb_wb_release_arbiter.sv
module tb_wb_release_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, jmp_valid;
  logic [4:0]  alu_rd, lsu_rd, jmp_rd;
  logic [31:0] alu_data, lsu_data, jmp_data;
  logic        alu_ready, lsu_ready, jmp_ready;
  logic        flush;
  logic        rf_we, rel_valid, release_all;
  logic [4:0]  rf_waddr, rel_rd;
  logic [31:0] rf_wdata, pend;

  int checks = 0;
  int failures = 0;
  logic [4:0]  exp_addr = 5'd0;
  logic [31:0] exp_data = 32'd0;

  wb_release_arbiter #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .jmp_valid(jmp_valid), .jmp_rd(jmp_rd), .jmp_data(jmp_data), .jmp_ready(jmp_ready),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rel_valid(rel_valid), .rel_rd(rel_rd),
    .release_all(release_all), .pend(pend)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] dat(input logic [4:0] rd);
    return 32'hD000_0000 | {27'd0, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write port check; address/data hold their last written value when idle.
  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr);
    if (we) begin
      exp_addr = addr;
      exp_data = dat(addr);
    end
    chk({tag, "_we"},    {31'd0, rf_we},     {31'd0, we});
    chk({tag, "_relv"},  {31'd0, rel_valid}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, rf_waddr},  {27'd0, exp_addr});
    chk({tag, "_relrd"}, {27'd0, rel_rd},    {27'd0, exp_addr});
    chk({tag, "_wdata"}, rf_wdata,           exp_data);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0; jmp_valid = 1'b0;
    alu_rd = 5'd0; lsu_rd = 5'd0; jmp_rd = 5'd0;
    alu_data = 32'd0; lsu_data = 32'd0; jmp_data = 32'd0;
    tick(); tick();
    chk_wr("reset", 1'b0, 5'd0);
    chk("reset_relall", {31'd0, release_all}, 32'd0);
    chk("reset_pend", pend, 32'd0);
    chk("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
    rst = 1'b0;

    // T2: simultaneous pushes drain ALU, LSU, JMP after reset
    alu_valid = 1; alu_rd = 5'd1; alu_data = dat(5'd1);
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = dat(5'd2);
    jmp_valid = 1; jmp_rd = 5'd3; jmp_data = dat(5'd3);
    tick();
    alu_valid = 0; lsu_valid = 0; jmp_valid = 0;
    chk_wr("t2_push", 1'b0, 5'd0);
    chk("t2_pend0", pend, 32'h0000_000E);
    tick(); chk_wr("t2_w1", 1'b1, 5'd1); chk("t2_pend1", pend, 32'h0000_000C);
    tick(); chk_wr("t2_w2", 1'b1, 5'd2);
    tick(); chk_wr("t2_w3", 1'b1, 5'd3); chk("t2_pend3", pend, 32'd0);
    alu_valid = 1; alu_rd = 5'd4; alu_data = dat(5'd4);
    lsu_valid = 1; lsu_rd = 5'd5; lsu_data = dat(5'd5);
    jmp_valid = 1; jmp_rd = 5'd6; jmp_data = dat(5'd6);
    tick();
    alu_valid = 0; lsu_valid = 0; jmp_valid = 0;
    chk_wr("t2b_push", 1'b0, 5'd0);
    chk("t2b_pend", pend, 32'h0000_0070);
    tick(); chk_wr("t2b_w4", 1'b1, 5'd4);
    tick(); chk_wr("t2b_w5", 1'b1, 5'd5);
    tick(); chk_wr("t2b_w6", 1'b1, 5'd6);

    // T1: single ALU result, one-cycle latency
    alu_valid = 1; alu_rd = 5'd5; alu_data = dat(5'd5);
    tick();
    alu_valid = 0;
    chk_wr("t1_push", 1'b0, 5'd0);
    chk("t1_pend", pend, 32'h0000_0020);
    tick(); chk_wr("t1_w", 1'b1, 5'd5); chk("t1_pend_clr", pend, 32'd0);
    tick(); chk_wr("t1_idle", 1'b0, 5'd0);

    // T4: rd==0 is accepted and discarded
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    #1;
    chk("t4_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 0;
    chk("t4_pend", pend, 32'd0);
    chk_wr("t4_a", 1'b0, 5'd0);
    tick(); chk_wr("t4_b", 1'b0, 5'd0);

    // Move the pointer to LSU with a lone load result
    lsu_valid = 1; lsu_rd = 5'd17; lsu_data = dat(5'd17);
    tick();
    lsu_valid = 0;
    chk_wr("pre3_push", 1'b0, 5'd0);
    tick(); chk_wr("pre3_w", 1'b1, 5'd17);

    // T3: LSU backs up while JMP and ALU win arbitration
    jmp_valid = 1; jmp_rd = 5'd10; jmp_data = dat(5'd10);
    alu_valid = 1; alu_rd = 5'd11; alu_data = dat(5'd11);
    lsu_valid = 1; lsu_rd = 5'd7;  lsu_data = dat(5'd7);
    tick();
    jmp_valid = 0; alu_valid = 0;
    lsu_rd = 5'd8; lsu_data = dat(5'd8);
    chk_wr("t3_e1", 1'b0, 5'd0);
    chk("t3_e1_pend", pend, 32'h0000_0C80);
    chk("t3_e1_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_rd = 5'd9; lsu_data = dat(5'd9);
    chk_wr("t3_e2", 1'b1, 5'd10);
    chk("t3_e2_pend", pend, 32'h0000_0980);
    chk("t3_e2_ready", {31'd0, lsu_ready}, 32'd0);
    tick();
    chk_wr("t3_e3", 1'b1, 5'd11);
    chk("t3_e3_pend", pend, 32'h0000_0180);
    chk("t3_e3_ready", {31'd0, lsu_ready}, 32'd0);
    tick();
    chk_wr("t3_e4", 1'b1, 5'd7);
    chk("t3_e4_pend", pend, 32'h0000_0100);
    chk("t3_e4_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 0;
    chk_wr("t3_e5", 1'b1, 5'd8);
    chk("t3_e5_pend", pend, 32'h0000_0200);
    tick(); chk_wr("t3_e6", 1'b1, 5'd9); chk("t3_e6_pend", pend, 32'd0);
    tick(); chk_wr("t3_e7", 1'b0, 5'd0);

    // T5: fill, then flush with a JMP result offered
    alu_valid = 1; alu_rd = 5'd1; alu_data = dat(5'd1);
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = dat(5'd2);
    jmp_valid = 1; jmp_rd = 5'd3; jmp_data = dat(5'd3);
    tick();
    chk_wr("t5_e1", 1'b0, 5'd0);
    alu_rd = 5'd4; alu_data = dat(5'd4);
    lsu_rd = 5'd5; lsu_data = dat(5'd5);
    jmp_rd = 5'd6; jmp_data = dat(5'd6);
    tick();
    alu_valid = 0; lsu_valid = 0;
    chk_wr("t5_e2", 1'b1, 5'd3);
    chk("t5_e2_pend", pend, 32'h0000_0076);
    chk("t5_alu_full", {31'd0, alu_ready}, 32'd0);
    chk("t5_lsu_full", {31'd0, lsu_ready}, 32'd0);
    flush = 1; jmp_rd = 5'd9; jmp_data = dat(5'd9);
    #1;
    chk("t5_jmp_ready_flush", {31'd0, jmp_ready}, 32'd0);
    tick();
    flush = 0; jmp_valid = 0;
    chk_wr("t5_flush", 1'b0, 5'd0);
    chk("t5_relall", {31'd0, release_all}, 32'd1);
    chk("t5_pend", pend, 32'd0);
    tick();
    chk_wr("t5_after1", 1'b0, 5'd0);
    chk("t5_relall_off", {31'd0, release_all}, 32'd0);
    flush = 1;
    tick(); chk("t5_hold1", {31'd0, release_all}, 32'd1);
    tick(); chk("t5_hold2", {31'd0, release_all}, 32'd1);
    flush = 0;
    tick();
    chk("t5_hold_end", {31'd0, release_all}, 32'd0);
    chk_wr("t5_after2", 1'b0, 5'd0);

    // T6: reset with entries buffered and flush asserted
    alu_valid = 1; alu_rd = 5'd20; alu_data = dat(5'd20);
    tick();
    alu_valid = 0;
    tick(); chk_wr("t6_w20", 1'b1, 5'd20);
    lsu_valid = 1; lsu_rd = 5'd11; lsu_data = dat(5'd11);
    jmp_valid = 1; jmp_rd = 5'd12; jmp_data = dat(5'd12);
    tick();
    lsu_valid = 0; jmp_valid = 0;
    chk("t6_pend_pre", pend, 32'h0000_1800);
    rst = 1; flush = 1;
    alu_valid = 1; alu_rd = 5'd21; alu_data = dat(5'd21);
    tick();
    exp_addr = 5'd0; exp_data = 32'd0;
    chk_wr("t6_rst", 1'b0, 5'd0);
    chk("t6_relall", {31'd0, release_all}, 32'd0);
    chk("t6_pend", pend, 32'd0);
    rst = 0; flush = 0;
    alu_rd = 5'd13; alu_data = dat(5'd13);
    lsu_valid = 1; lsu_rd = 5'd14; lsu_data = dat(5'd14);
    jmp_valid = 1; jmp_rd = 5'd15; jmp_data = dat(5'd15);
    tick();
    alu_valid = 0; lsu_valid = 0; jmp_valid = 0;
    chk("t6_pend_post", pend, 32'h0000_E000);
    tick(); chk_wr("t6_w13", 1'b1, 5'd13);
    tick(); chk_wr("t6_w14", 1'b1, 5'd14);
    tick(); chk_wr("t6_w15", 1'b1, 5'd15);
    tick(); chk_wr("t6_idle", 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
